// File: rtl/fetch_pipeline.sv
// Instruction fetch front end: drives program-memory addresses, absorbs stalls and
// branch flushes, and delivers a STAGES-deep registered instruction stream to the decoder.
module fetch_pipeline #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                STAGES   = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(8'hC8),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump,
    input  logic              conditional_jump,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [DATA_W-1:0] pm_data,
    output logic [ADDR_W-1:0] pm_address,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir_data,
    output logic              ir_valid,
    output logic              flush_pipeline,
    output logic [CNT_W-1:0]  branch_count
);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("fetch_pipeline: STAGES must be within 1..4");
        end
    endgenerate

    logic              take;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [DATA_W-1:0] stg_data_d [STAGES];
    logic [DATA_W-1:0] stg_data_q [STAGES];
    logic [STAGES-1:0] stg_vld_d, stg_vld_q;
    logic [CNT_W-1:0]  branch_count_d, branch_count_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Address select: reset > branch > stall (re-fetch pc) > sequential.
    always_comb begin
        take = jump | (conditional_jump & ~zero_flag);
        pc_d = pc_q + ADDR_W'(1);
        if (!reset) begin
            pc_d = '0;
        end else if (take) begin
            pc_d = jump_addr;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // Stage 0 captures the returning memory word; later stages shift behind it.
    // A flush or stall discards the word on pm_data this cycle.
    always_comb begin
        stg_data_d = stg_data_q;
        stg_vld_d  = stg_vld_q;
        if (!reset || take) begin
            stg_vld_d = '0;
        end else if (!stall) begin
            stg_data_d[0] = pm_data;
            stg_vld_d[0]  = 1'b1;
            for (int k = 1; k < STAGES; k++) begin
                stg_data_d[k] = stg_data_q[k-1];
                stg_vld_d[k]  = stg_vld_q[k-1];
            end
        end
    end

    always_comb begin
        branch_count_d = branch_count_q;
        if (!reset) begin
            branch_count_d = '0;
        end else if (take) begin
            branch_count_d = sat_inc(branch_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q           <= '0;
            stg_vld_q      <= '0;
            branch_count_q <= '0;
        end else begin
            pc_q           <= pc_d;
            stg_vld_q      <= stg_vld_d;
            branch_count_q <= branch_count_d;
        end
    end

    // Data words carry no reset; the valid bits alone decide what the decoder sees.
    always_ff @(posedge clk) begin
        stg_data_q <= stg_data_d;
    end

    assign pm_address     = pc_d;
    assign pc             = pc_q;
    assign ir_valid       = stg_vld_q[STAGES-1];
    assign ir_data        = stg_vld_q[STAGES-1] ? stg_data_q[STAGES-1] : NOP_WORD;
    assign flush_pipeline = take & reset;
    assign branch_count   = branch_count_q;

endmodule

// File: tb/tb_fetch_pipeline.sv
// Directed bench for fetch_pipeline: three instances (STAGES 1/3/2, the last with a
// 4-bit address and 4-bit counter) share one stimulus stream, each with mem[a] = a + 8'h10.
module tb_fetch_pipeline;

    logic       clk = 1'b0;
    logic       reset, stall, jump, cj, zf;
    logic [7:0] ja;

    logic [7:0]  pm_address1, pc1, ir1, pm_data1;
    logic        irv1, fl1;
    logic [15:0] bc1;

    logic [7:0]  pm_address3, pc3, ir3, pm_data3;
    logic        irv3, fl3;
    logic [3:0]  bc3;

    logic [3:0]  pm_address2, pc2;
    logic [7:0]  ir2, pm_data2;
    logic        irv2, fl2;
    logic [3:0]  bc2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_pipeline #(.STAGES(1)) u1 (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .conditional_jump(cj),
        .zero_flag(zf), .jump_addr(ja), .pm_data(pm_data1), .pm_address(pm_address1),
        .pc(pc1), .ir_data(ir1), .ir_valid(irv1), .flush_pipeline(fl1), .branch_count(bc1));

    fetch_pipeline #(.STAGES(3), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .conditional_jump(cj),
        .zero_flag(zf), .jump_addr(ja), .pm_data(pm_data3), .pm_address(pm_address3),
        .pc(pc3), .ir_data(ir3), .ir_valid(irv3), .flush_pipeline(fl3), .branch_count(bc3));

    fetch_pipeline #(.ADDR_W(4), .STAGES(2), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .conditional_jump(cj),
        .zero_flag(zf), .jump_addr(ja[3:0]), .pm_data(pm_data2), .pm_address(pm_address2),
        .pc(pc2), .ir_data(ir2), .ir_valid(irv2), .flush_pipeline(fl2), .branch_count(bc2));

    // Synchronous program memories
    always_ff @(posedge clk) begin
        pm_data1 <= pm_address1 + 8'h10;
        pm_data3 <= pm_address3 + 8'h10;
        pm_data2 <= {4'h0, pm_address2} + 8'h10;
    end

    // One cycle: drive inputs after the falling edge, leave 1 time unit to settle.
    task automatic cyc(input logic r, input logic st, input logic j, input logic c,
                       input logic z, input logic [7:0] a);
        @(negedge clk);
        reset = r; stall = st; jump = j; cj = c; zf = z; ja = a;
        #1;
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0, 1, 1, 0, 0, 8'h55);
        total++; if (pm_address1 !== 8'h00) $display("FAIL rst_pm_address: got %h want 00", pm_address1); else passed++;
        total++; if (fl1 !== 1'b0) $display("FAIL rst_flush: got %b want 0", fl1); else passed++;
        total++; if (irv3 !== 1'b0) $display("FAIL rst_ir_valid: got %b want 0", irv3); else passed++;
        total++; if (ir1 !== 8'hC8) $display("FAIL rst_ir_data: got %h want c8", ir1); else passed++;
        total++; if (pc1 !== 8'h00) $display("FAIL rst_pc: got %h want 00", pc1); else passed++;
        total++; if (bc1 !== 16'd0) $display("FAIL rst_branch_count: got %0d want 0", bc1); else passed++;
    endtask

    task automatic test_sequential();
        logic [7:0] e;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 0, 0, 0, 8'h00);
            total++; if (pm_address1 !== 8'(k + 1)) $display("FAIL seq_pm_address k=%0d: got %h want %h", k, pm_address1, 8'(k + 1)); else passed++;
            e = (k >= 1) ? 8'(8'h10 + k - 1) : 8'hC8;
            total++; if (ir1 !== e) $display("FAIL seq_ir1 k=%0d: got %h want %h", k, ir1, e); else passed++;
            e = (k >= 3) ? 8'(8'h10 + k - 3) : 8'hC8;
            total++; if (ir3 !== e) $display("FAIL seq_ir3 k=%0d: got %h want %h", k, ir3, e); else passed++;
            total++; if (irv3 !== (k >= 3)) $display("FAIL seq_irv3 k=%0d: got %b want %b", k, irv3, (k >= 3)); else passed++;
        end
    endtask

    task automatic test_jump();
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 0, 8'h40);
        total++; if (fl3 !== 1'b1) $display("FAIL jmp_flush: got %b want 1", fl3); else passed++;
        total++; if (pm_address3 !== 8'h40) $display("FAIL jmp_pm_address: got %h want 40", pm_address3); else passed++;
        total++; if (ir3 !== 8'h11) $display("FAIL jmp_ir_before: got %h want 11", ir3); else passed++;
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 0, 0, 0, 8'h00);
            if (i <= 3) begin
                total++; if (ir3 !== 8'hC8 || irv3 !== 1'b0) $display("FAIL jmp_bubble t+%0d: got %h/%b want c8/0", i, ir3, irv3); else passed++;
            end else begin
                total++; if (ir3 !== 8'h50 || irv3 !== 1'b1) $display("FAIL jmp_target t+4: got %h/%b want 50/1", ir3, irv3); else passed++;
            end
            if (i == 1) begin
                total++; if (fl3 !== 1'b0) $display("FAIL jmp_flush_after: got %b want 0", fl3); else passed++;
                total++; if (pm_address3 !== 8'h41) $display("FAIL jmp_next_addr: got %h want 41", pm_address3); else passed++;
                total++; if (ir1 !== 8'hC8) $display("FAIL jmp_ir1_bubble: got %h want c8", ir1); else passed++;
            end
            if (i == 2) begin
                total++; if (ir1 !== 8'h50) $display("FAIL jmp_ir1_target: got %h want 50", ir1); else passed++;
            end
        end
        total++; if (bc3 !== 4'd1) $display("FAIL jmp_count: got %0d want 1", bc3); else passed++;
    endtask

    task automatic test_conditional();
        do_reset();
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 1, 1, 8'h80);
        total++; if (fl1 !== 1'b0) $display("FAIL cj_zero_flush: got %b want 0", fl1); else passed++;
        total++; if (pm_address1 !== 8'h03) $display("FAIL cj_zero_addr: got %h want 03", pm_address1); else passed++;
        cyc(1, 0, 0, 1, 0, 8'h80);
        total++; if (ir1 !== 8'h12) $display("FAIL cj_ir_seq: got %h want 12", ir1); else passed++;
        total++; if (fl1 !== 1'b1) $display("FAIL cj_taken_flush: got %b want 1", fl1); else passed++;
        total++; if (pm_address1 !== 8'h80) $display("FAIL cj_taken_addr: got %h want 80", pm_address1); else passed++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (ir1 !== 8'hC8) $display("FAIL cj_bubble: got %h want c8", ir1); else passed++;
        total++; if (pm_address1 !== 8'h81) $display("FAIL cj_next_addr: got %h want 81", pm_address1); else passed++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (ir1 !== 8'h90) $display("FAIL cj_target: got %h want 90", ir1); else passed++;
        total++; if (bc1 !== 16'd1) $display("FAIL cj_count: got %0d want 1", bc1); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 8'h00);
        for (int k = 4; k < 7; k++) begin
            cyc(1, 1, 0, 0, 0, 8'h00);
            total++; if (pm_address2 !== 4'd4) $display("FAIL stall_addr k=%0d: got %h want 4", k, pm_address2); else passed++;
            total++; if (ir2 !== 8'h12) $display("FAIL stall_ir2 k=%0d: got %h want 12", k, ir2); else passed++;
            total++; if (pc2 !== 4'd4) $display("FAIL stall_pc k=%0d: got %h want 4", k, pc2); else passed++;
            total++; if (ir1 !== 8'h13) $display("FAIL stall_ir1 k=%0d: got %h want 13", k, ir1); else passed++;
        end
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (pm_address2 !== 4'd5) $display("FAIL stall_release_addr: got %h want 5", pm_address2); else passed++;
        total++; if (ir2 !== 8'h12) $display("FAIL stall_release_ir: got %h want 12", ir2); else passed++;
        for (int k = 8; k < 11; k++) begin
            cyc(1, 0, 0, 0, 0, 8'h00);
            total++; if (ir2 !== 8'(8'h13 + k - 8)) $display("FAIL stall_resume k=%0d: got %h want %h", k, ir2, 8'(8'h13 + k - 8)); else passed++;
        end
        cyc(1, 1, 1, 0, 0, 8'h06);
        total++; if (fl2 !== 1'b1) $display("FAIL stall_jump_flush: got %b want 1", fl2); else passed++;
        total++; if (pm_address2 !== 4'd6) $display("FAIL stall_jump_addr: got %h want 6", pm_address2); else passed++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (irv2 !== 1'b0 || pc2 !== 4'd6) $display("FAIL stall_jump_b1: got %b/%h want 0/6", irv2, pc2); else passed++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (irv2 !== 1'b0) $display("FAIL stall_jump_b2: got %b want 0", irv2); else passed++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (ir2 !== 8'h16 || irv2 !== 1'b1) $display("FAIL stall_jump_target: got %h/%b want 16/1", ir2, irv2); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, 0, 0, 0, 8'h00);
            total++; if (pm_address2 !== 4'(k + 1)) $display("FAIL wrap_addr k=%0d: got %h want %h", k, pm_address2, 4'(k + 1)); else passed++;
            if (k >= 2) begin
                total++; if (ir2 !== 8'(8'h10 + ((k - 2) % 16))) $display("FAIL wrap_ir k=%0d: got %h want %h", k, ir2, 8'(8'h10 + ((k - 2) % 16))); else passed++;
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 19; i++) begin
            cyc(1, 0, 1, 0, 0, 8'h00);
            if (i == 14) begin
                total++; if (bc2 !== 4'd14) $display("FAIL sat_count_14: got %0d want 14", bc2); else passed++;
            end
            if (i == 16) begin
                total++; if (bc2 !== 4'd15) $display("FAIL sat_count_16: got %0d want 15", bc2); else passed++;
            end
        end
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (bc2 !== 4'd15) $display("FAIL sat_count_u2: got %0d want 15", bc2); else passed++;
        total++; if (bc3 !== 4'd15) $display("FAIL sat_count_u3: got %0d want 15", bc3); else passed++;
        total++; if (bc1 !== 16'd19) $display("FAIL sat_count_u1: got %0d want 19", bc1); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 0, 8'h20);
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'h30);
        total++; if (pm_address1 !== 8'h00 || fl1 !== 1'b0) $display("FAIL mid_rst_comb: got %h/%b want 00/0", pm_address1, fl1); else passed++;
        total++; if (bc1 !== 16'd1) $display("FAIL mid_rst_count_before: got %0d want 1", bc1); else passed++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (pc1 !== 8'h00 || irv1 !== 1'b0) $display("FAIL mid_rst_state: got %h/%b want 00/0", pc1, irv1); else passed++;
        total++; if (bc1 !== 16'd0) $display("FAIL mid_rst_count: got %0d want 0", bc1); else passed++;
        total++; if (pm_address1 !== 8'h01) $display("FAIL mid_rst_addr: got %h want 01", pm_address1); else passed++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (ir1 !== 8'h10 || irv1 !== 1'b1) $display("FAIL mid_rst_resume: got %h/%b want 10/1", ir1, irv1); else passed++;
        cyc(1, 0, 0, 0, 0, 8'h00);
        total++; if (ir2 !== 8'h10 || ir1 !== 8'h11) $display("FAIL mid_rst_resume2: got %h/%h want 10/11", ir2, ir1); else passed++;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; jump = 1'b0; cj = 1'b0; zf = 1'b0; ja = 8'h00;
        test_reset();
        test_sequential();
        test_jump();
        test_conditional();
        test_stall();
        test_wrap();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
